// File: rtl/mem_access_unit.sv
// MEM-stage data-memory initiator: issues one valid/ready bus request per load/store,
// aligns and extends load data, and holds the pipeline while the access is in flight.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_m,
  input  logic        MemRead_m,
  input  logic        MemWrite_m,
  input  logic [2:0]  funct3_m,
  input  logic [31:0] ALUResult_m,
  input  logic [31:0] WriteData_m,
  output logic        stall_m,
  output logic [31:0] FinalDataMemoryRead_m,
  output logic        access_fault_m,
  output logic        bus_err_m,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_rsp_valid,
  input  logic        dmem_rsp_err,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic [2:0]           funct3_q;
  logic [1:0]           off_q;
  logic                 load_q;

  logic op;
  logic is_load;
  logic size_ok;
  logic align_ok;
  logic access_ok;
  logic timeout;

  function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                               input logic [1:0]  off,
                                               input logic [31:0] word);
    logic [31:0] lane;
    lane = word >> {off, 3'b000};
    case (f3)
      3'b000:  load_extract = {{24{lane[7]}}, lane[7:0]};
      3'b100:  load_extract = {24'd0, lane[7:0]};
      3'b001:  load_extract = {{16{lane[15]}}, lane[15:0]};
      3'b101:  load_extract = {16'd0, lane[15:0]};
      default: load_extract = word;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   store_strb = 4'b0001 << off;
      2'b01:   store_strb = 4'b0011 << off;
      default: store_strb = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   store_data = {4{wd[7:0]}};
      2'b01:   store_data = {2{wd[15:0]}};
      default: store_data = wd;
    endcase
  endfunction

  assign op      = valid_m & (MemRead_m | MemWrite_m);
  // A simultaneous read+write request is served as a load.
  assign is_load = MemRead_m;

  always_comb begin
    size_ok  = 1'b0;
    align_ok = 1'b0;
    case (funct3_m)
      3'b000, 3'b001, 3'b010: size_ok = 1'b1;
      3'b100, 3'b101:         size_ok = is_load;
      default:                size_ok = 1'b0;
    endcase
    case (funct3_m[1:0])
      2'b00:   align_ok = 1'b1;
      2'b01:   align_ok = ~ALUResult_m[0];
      2'b10:   align_ok = (ALUResult_m[1:0] == 2'b00);
      default: align_ok = 1'b0;
    endcase
  end

  assign access_ok = size_ok & align_ok;
  assign timeout   = (cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

  // Gating with reset keeps the pipeline free the instant reset is asserted.
  assign stall_m        = reset & op & (state != DONE);
  assign dmem_req_valid = (state == REQ);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (op) state_nxt = access_ok ? REQ : DONE;
      REQ:  if (dmem_req_ready) state_nxt = WAIT;
      WAIT: if (dmem_rsp_valid || timeout) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt                   <= '0;
      funct3_q              <= 3'd0;
      off_q                 <= 2'd0;
      load_q                <= 1'b0;
      FinalDataMemoryRead_m <= 32'd0;
      access_fault_m        <= 1'b0;
      bus_err_m             <= 1'b0;
      dmem_we               <= 1'b0;
      dmem_addr             <= 32'd0;
      dmem_wstrb            <= 4'd0;
      dmem_wdata            <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (op) begin
            access_fault_m <= ~access_ok;
            bus_err_m      <= 1'b0;
            if (access_ok) begin
              funct3_q   <= funct3_m;
              off_q      <= ALUResult_m[1:0];
              load_q     <= is_load;
              dmem_we    <= ~is_load;
              dmem_addr  <= {ALUResult_m[31:2], 2'b00};
              dmem_wstrb <= is_load ? 4'b0000 : store_strb(funct3_m, ALUResult_m[1:0]);
              dmem_wdata <= is_load ? 32'd0 : store_data(funct3_m, WriteData_m);
            end else begin
              FinalDataMemoryRead_m <= 32'd0;
            end
          end
        end
        REQ: begin
          if (dmem_req_ready) cnt <= '0;
        end
        WAIT: begin
          cnt <= cnt + CNT_WIDTH'(1);
          if (dmem_rsp_valid) begin
            bus_err_m <= dmem_rsp_err;
            if (load_q)
              FinalDataMemoryRead_m <= dmem_rsp_err ? 32'd0
                                                    : load_extract(funct3_q, off_q, dmem_rdata);
          end else if (timeout) begin
            bus_err_m             <= 1'b1;
            FinalDataMemoryRead_m <= 32'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a small bus responder plus per-scenario tasks
// comparing the unit's outputs against hand-computed values.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid_m = 1'b0;
  logic        MemRead_m = 1'b0;
  logic        MemWrite_m = 1'b0;
  logic [2:0]  funct3_m = 3'd0;
  logic [31:0] ALUResult_m = 32'd0;
  logic [31:0] WriteData_m = 32'd0;
  logic        stall_m;
  logic [31:0] FinalDataMemoryRead_m;
  logic        access_fault_m;
  logic        bus_err_m;
  logic        dmem_req_valid;
  logic        dmem_req_ready = 1'b0;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_rsp_valid = 1'b0;
  logic        dmem_rsp_err = 1'b0;
  logic [31:0] dmem_rdata = 32'd0;

  int n_checks = 0;
  int n_fail   = 0;

  int          stalls;
  bit          seen, stable, hung;
  logic [31:0] c_addr, c_wdata;
  logic [3:0]  c_strb;
  logic        c_we;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(16), .CNT_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .valid_m(valid_m), .MemRead_m(MemRead_m),
    .MemWrite_m(MemWrite_m), .funct3_m(funct3_m), .ALUResult_m(ALUResult_m),
    .WriteData_m(WriteData_m), .stall_m(stall_m),
    .FinalDataMemoryRead_m(FinalDataMemoryRead_m), .access_fault_m(access_fault_m),
    .bus_err_m(bus_err_m), .dmem_req_valid(dmem_req_valid),
    .dmem_req_ready(dmem_req_ready), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata), .dmem_rsp_valid(dmem_rsp_valid),
    .dmem_rsp_err(dmem_rsp_err), .dmem_rdata(dmem_rdata)
  );

  // Called at posedge+1 in IDLE; returns at posedge+2 of the DONE cycle.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] word, input logic err,
                            input int ready_delay, input bit respond);
    int req_cycles;
    bit hs;
    req_cycles = 0; hs = 0;
    stalls = 0; seen = 0; stable = 1; hung = 1;
    c_addr = 32'd0; c_wdata = 32'd0; c_strb = 4'd0; c_we = 1'b0;
    valid_m = 1'b1; MemRead_m = rd; MemWrite_m = wr; funct3_m = f3;
    ALUResult_m = addr; WriteData_m = wd; dmem_rdata = word; dmem_rsp_err = err;
    for (int i = 0; i < 100; i++) begin
      dmem_req_ready = 1'b0;
      dmem_rsp_valid = 1'b0;
      #1;
      if (!stall_m) begin
        hung = 0;
        break;
      end
      stalls++;
      if (dmem_req_valid) begin
        if (!seen) begin
          c_addr = dmem_addr; c_wdata = dmem_wdata; c_strb = dmem_wstrb; c_we = dmem_we;
        end else if (c_addr !== dmem_addr || c_wdata !== dmem_wdata ||
                     c_strb !== dmem_wstrb || c_we !== dmem_we) begin
          stable = 0;
        end
        seen = 1;
        if (req_cycles >= ready_delay) begin
          dmem_req_ready = 1'b1;
          hs = 1;
        end
        req_cycles++;
      end else if (hs && respond) begin
        dmem_rsp_valid = 1'b1;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic finish_access();
    valid_m = 1'b0; MemRead_m = 1'b0; MemWrite_m = 1'b0;
    dmem_rsp_err = 1'b0; dmem_rsp_valid = 1'b0; dmem_req_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    valid_m = 1'b1; MemRead_m = 1'b1; funct3_m = 3'b010;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (stall_m !== 1'b0) begin
      n_fail++; $display("FAIL reset_stall: got %b expected 0", stall_m);
    end
    n_checks++;
    if (dmem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_req_valid: got %b expected 0", dmem_req_valid);
    end
    n_checks++;
    if ({FinalDataMemoryRead_m, access_fault_m, bus_err_m, dmem_we, dmem_addr,
         dmem_wstrb, dmem_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got data=%h af=%b be=%b we=%b addr=%h strb=%b wdata=%h expected all 0",
               FinalDataMemoryRead_m, access_fault_m, bus_err_m, dmem_we, dmem_addr,
               dmem_wstrb, dmem_wdata);
    end
    valid_m = 1'b0; MemRead_m = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_lw();
    run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 1'b0, 0, 1'b1);
    n_checks++;
    if (hung) begin n_fail++; $display("FAIL lw_done: got hung expected DONE"); end
    n_checks++;
    if (stalls != 3) begin n_fail++; $display("FAIL lw_stalls: got %0d expected 3", stalls); end
    n_checks++;
    if (c_addr !== 32'h100 || c_we !== 1'b0 || c_strb !== 4'b0000) begin
      n_fail++; $display("FAIL lw_req: got addr=%h we=%b strb=%b expected 00000100 0 0000", c_addr, c_we, c_strb);
    end
    n_checks++;
    if (FinalDataMemoryRead_m !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL lw_data: got %h expected deadbeef", FinalDataMemoryRead_m);
    end
    n_checks++;
    if (access_fault_m !== 1'b0 || bus_err_m !== 1'b0) begin
      n_fail++; $display("FAIL lw_flags: got af=%b be=%b expected 0 0", access_fault_m, bus_err_m);
    end
    finish_access();
  endtask

  task automatic test_load_extract();
    logic [2:0]  f3s  [5] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b000};
    logic [31:0] adrs [5] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100};
    logic [31:0] exps [5] = '{32'hFFFFFF80, 32'h00000080, 32'h00008011, 32'hFFFF8011, 32'h00000033};
    for (int i = 0; i < 5; i++) begin
      run_access(1'b1, 1'b0, f3s[i], adrs[i], 32'd0, 32'h80112233, 1'b0, 0, 1'b1);
      n_checks++;
      if (hung || FinalDataMemoryRead_m !== exps[i]) begin
        n_fail++; $display("FAIL extract_%0d: got %h (hung=%b) expected %h", i, FinalDataMemoryRead_m, hung, exps[i]);
      end
      n_checks++;
      if (c_addr !== 32'h100) begin
        n_fail++; $display("FAIL extract_addr_%0d: got %h expected 00000100", i, c_addr);
      end
      finish_access();
    end
  endtask

  task automatic test_store();
    run_access(1'b0, 1'b1, 3'b000, 32'h201, 32'h000000A5, 32'd0, 1'b0, 4, 1'b1);
    n_checks++;
    if (hung || stalls != 7) begin n_fail++; $display("FAIL sb_stalls: got %0d (hung=%b) expected 7", stalls, hung); end
    n_checks++;
    if (c_addr !== 32'h200 || c_strb !== 4'b0010 || c_wdata !== 32'hA5A5A5A5 || c_we !== 1'b1) begin
      n_fail++; $display("FAIL sb_req: got addr=%h strb=%b wdata=%h we=%b expected 00000200 0010 a5a5a5a5 1", c_addr, c_strb, c_wdata, c_we);
    end
    n_checks++;
    if (!stable) begin n_fail++; $display("FAIL sb_stable: got unstable request expected stable"); end
    n_checks++;
    if (bus_err_m !== 1'b0 || access_fault_m !== 1'b0) begin
      n_fail++; $display("FAIL sb_flags: got af=%b be=%b expected 0 0", access_fault_m, bus_err_m);
    end
    finish_access();
    run_access(1'b0, 1'b1, 3'b001, 32'h202, 32'h00001234, 32'd0, 1'b0, 0, 1'b1);
    n_checks++;
    if (hung || stalls != 3 || c_strb !== 4'b1100 || c_wdata !== 32'h12341234 || c_addr !== 32'h200) begin
      n_fail++; $display("FAIL sh_req: got stalls=%0d strb=%b wdata=%h addr=%h expected 3 1100 12341234 00000200", stalls, c_strb, c_wdata, c_addr);
    end
    finish_access();
    run_access(1'b0, 1'b1, 3'b010, 32'h204, 32'hCAFEF00D, 32'd0, 1'b0, 0, 1'b1);
    n_checks++;
    if (hung || c_strb !== 4'b1111 || c_wdata !== 32'hCAFEF00D || c_addr !== 32'h204) begin
      n_fail++; $display("FAIL sw_req: got strb=%b wdata=%h addr=%h expected 1111 cafef00d 00000204", c_strb, c_wdata, c_addr);
    end
    finish_access();
  endtask

  task automatic test_fault();
    logic       rds [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [2:0] f3s [4] = '{3'b010, 3'b011, 3'b100, 3'b001};
    logic [31:0] ads[4] = '{32'h102, 32'h100, 32'h100, 32'h101};
    for (int i = 0; i < 4; i++) begin
      run_access(rds[i], ~rds[i], f3s[i], ads[i], 32'hFFFFFFFF, 32'h55555555, 1'b0, 0, 1'b1);
      n_checks++;
      if (hung || seen || stalls != 1) begin
        n_fail++; $display("FAIL fault_seq_%0d: got stalls=%0d req_seen=%b hung=%b expected 1 0 0", i, stalls, seen, hung);
      end
      n_checks++;
      if (access_fault_m !== 1'b1 || (rds[i] && FinalDataMemoryRead_m !== 32'd0)) begin
        n_fail++; $display("FAIL fault_flag_%0d: got af=%b data=%h expected 1 00000000", i, access_fault_m, FinalDataMemoryRead_m);
      end
      finish_access();
    end
    run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 32'h12345678, 1'b0, 0, 1'b1);
    n_checks++;
    if (hung || access_fault_m !== 1'b0 || FinalDataMemoryRead_m !== 32'h12345678) begin
      n_fail++; $display("FAIL fault_clear: got af=%b data=%h expected 0 12345678", access_fault_m, FinalDataMemoryRead_m);
    end
    finish_access();
  endtask

  task automatic test_bus_error();
    run_access(1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 32'hFFFFFFFF, 1'b1, 0, 1'b1);
    n_checks++;
    if (hung || stalls != 3 || bus_err_m !== 1'b1 || FinalDataMemoryRead_m !== 32'd0) begin
      n_fail++; $display("FAIL rsp_err: got stalls=%0d be=%b data=%h expected 3 1 00000000", stalls, bus_err_m, FinalDataMemoryRead_m);
    end
    finish_access();
    run_access(1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 32'h11111111, 1'b0, 0, 1'b0);
    n_checks++;
    if (hung || stalls != 18) begin n_fail++; $display("FAIL timeout_stalls: got %0d (hung=%b) expected 18", stalls, hung); end
    n_checks++;
    if (bus_err_m !== 1'b1 || FinalDataMemoryRead_m !== 32'd0 || access_fault_m !== 1'b0) begin
      n_fail++; $display("FAIL timeout_flags: got be=%b data=%h af=%b expected 1 00000000 0", bus_err_m, FinalDataMemoryRead_m, access_fault_m);
    end
    valid_m = 1'b0; MemRead_m = 1'b0; dmem_rsp_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    dmem_rsp_valid = 1'b0;
    n_checks++;
    if (bus_err_m !== 1'b1 || FinalDataMemoryRead_m !== 32'd0 || dmem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL late_rsp: got be=%b data=%h req=%b expected 1 00000000 0", bus_err_m, FinalDataMemoryRead_m, dmem_req_valid);
    end
    run_access(1'b1, 1'b0, 3'b010, 32'h308, 32'd0, 32'h13572468, 1'b0, 0, 1'b1);
    n_checks++;
    if (hung || stalls != 3 || bus_err_m !== 1'b0 || FinalDataMemoryRead_m !== 32'h13572468) begin
      n_fail++; $display("FAIL after_timeout: got stalls=%0d be=%b data=%h expected 3 0 13572468", stalls, bus_err_m, FinalDataMemoryRead_m);
    end
    finish_access();
  endtask

  task automatic test_reset_mid();
    valid_m = 1'b1; MemRead_m = 1'b1; funct3_m = 3'b010; ALUResult_m = 32'h400;
    dmem_req_ready = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    dmem_req_ready = 1'b0;
    #1;
    n_checks++;
    if (stall_m !== 1'b1 || dmem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_wait: got stall=%b req=%b expected 1 0", stall_m, dmem_req_valid);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (stall_m !== 1'b0 || dmem_req_valid !== 1'b0 || FinalDataMemoryRead_m !== 32'd0) begin
      n_fail++; $display("FAIL mid_reset: got stall=%b req=%b data=%h expected 0 0 00000000", stall_m, dmem_req_valid, FinalDataMemoryRead_m);
    end
    @(posedge clk); #1;
    reset = 1'b1; valid_m = 1'b0; MemRead_m = 1'b0;
    dmem_rsp_valid = 1'b1; dmem_rdata = 32'h99999999;
    @(posedge clk); #1;
    dmem_rsp_valid = 1'b0;
    n_checks++;
    if (FinalDataMemoryRead_m !== 32'd0 || bus_err_m !== 1'b0 || dmem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_rsp: got data=%h be=%b req=%b expected 00000000 0 0", FinalDataMemoryRead_m, bus_err_m, dmem_req_valid);
    end
    run_access(1'b1, 1'b0, 3'b010, 32'h104, 32'd0, 32'h0BADF00D, 1'b0, 0, 1'b1);
    n_checks++;
    if (hung || stalls != 3 || FinalDataMemoryRead_m !== 32'h0BADF00D || c_addr !== 32'h104) begin
      n_fail++; $display("FAIL post_reset_lw: got stalls=%0d data=%h addr=%h expected 3 0badf00d 00000104", stalls, FinalDataMemoryRead_m, c_addr);
    end
    finish_access();
  endtask

  task automatic test_back_to_back();
    run_access(1'b1, 1'b0, 3'b010, 32'h500, 32'd0, 32'hAAAA5555, 1'b0, 0, 1'b1);
    n_checks++;
    if (hung || stalls != 3 || FinalDataMemoryRead_m !== 32'hAAAA5555) begin
      n_fail++; $display("FAIL b2b_first: got stalls=%0d data=%h expected 3 aaaa5555", stalls, FinalDataMemoryRead_m);
    end
    @(posedge clk); #1;
    run_access(1'b1, 1'b0, 3'b100, 32'h501, 32'd0, 32'h0000C300, 1'b0, 0, 1'b1);
    n_checks++;
    if (hung || stalls != 3 || FinalDataMemoryRead_m !== 32'h000000C3) begin
      n_fail++; $display("FAIL b2b_second: got stalls=%0d data=%h expected 3 000000c3", stalls, FinalDataMemoryRead_m);
    end
    finish_access();
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_extract();
    test_store();
    test_fault();
    test_bus_error();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage data-memory initiator. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Takes address and store data from EX/MEM and issues one request per load/store on a valid/ready data-memory bus.
- Waits for the response, then aligns and sign/zero-extends load data into FinalDataMemoryRead_m.
- Holds the pipeline via stall_m while the access is in flight, and flags misaligned/illegal accesses and bus errors/timeouts.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles spent in WAIT before a bus error is declared (>=2).
- CNT_WIDTH, 5, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- valid_m  in  1  EX/MEM holds a live instruction.
- MemRead_m  in  1  instruction is a load.
- MemWrite_m  in  1  instruction is a store.
- funct3_m  in  3  access size/sign (RV32I encoding).
- ALUResult_m  in  32  byte address.
- WriteData_m  in  32  store data, right-justified.
- stall_m  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; bubble into MEM/WB.
- FinalDataMemoryRead_m  out  32  extended load data.
- access_fault_m  out  1  misaligned or illegal-funct3 access; valid in DONE.
- bus_err_m  out  1  response error or timeout; valid in DONE.
- dmem_req_valid  out  1  request valid.
- dmem_req_ready  in  1  responder accepts request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word-aligned address ({ALUResult_m[31:2],2'b00}).
- dmem_wstrb  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_rsp_valid  in  1  response (read data or write ack) valid.
- dmem_rsp_err  in  1  response carries error; qualified by rsp_valid.
- dmem_rdata  in  32  read word.

Behaviour:
- Reset (async, reset=0): state=IDLE, counter=0.
  - All outputs 0: stall_m, FinalDataMemoryRead_m, access_fault_m, bus_err_m, dmem_req_valid, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata.
  - Reset mid-operation abandons the access; req_valid drops immediately.
- op = valid_m & (MemRead_m | MemWrite_m). If both MemRead_m and MemWrite_m are set, the access is treated as a load.
- stall_m (combinational) = op & (state != DONE).
- States: IDLE, REQ, WAIT, DONE.
- IDLE, no op: stay; outputs hold last values. MEM/WB only consumes the data when MemRead.
- IDLE, op with legal funct3 and aligned address: register addr/we/wstrb/wdata and go to REQ.
  - Aligned: byte always; half needs addr[0]=0; word needs addr[1:0]=0.
- IDLE, op that is misaligned, or funct3 in {011,110,111}, or store funct3 >010: no bus request; go to DONE with access_fault_m=1 and data 0.
- REQ: dmem_req_valid=1; addr/we/wstrb/wdata stay stable until handshake.
  - On req_valid & req_ready: go to WAIT, counter=0.
  - rsp_valid is ignored in REQ; the responder may not respond in the handshake cycle.
- WAIT: counter increments each cycle.
  - On rsp_valid: go to DONE. Set bus_err_m=rsp_err. For a load, FinalDataMemoryRead_m = extract(rdata), or 0 if rsp_err.
  - Otherwise, if counter == TIMEOUT_CYCLES-1: go to DONE with bus_err_m=1 and data 0. A late response after this is ignored.
- DONE: stall_m=0 for exactly one cycle, so MEM/WB captures the data. Next state is IDLE.
  - access_fault_m/bus_err_m are cleared on the next access start.
- Load extract, with sh = addr[1:0]*8:
  - LB: sign-extend rdata[sh+7:sh].
  - LBU: zero-extend rdata[sh+7:sh].
  - LH: sign-extend rdata[sh+15:sh].
  - LHU: zero-extend rdata[sh+15:sh].
  - LW: rdata.
- Store:
  - SB: wstrb = 0001<<addr[1:0]; wdata = {4{WriteData_m[7:0]}}.
  - SH: wstrb = 0011<<addr[1:0]; wdata = {2{WriteData_m[15:0]}}.
  - SW: wstrb = 1111; wdata = WriteData_m.
  - Loads: wstrb = 0000, we = 0.
- Minimum latency (ready and rsp each on first opportunity): 3 stall cycles, then the DONE cycle.
- rsp_valid in IDLE or DONE is ignored.

Test Plan:
- LW addr 0x100; ready in REQ cycle 1, rdata=0xDEADBEEF next cycle → dmem_addr=0x100, we=0, stall_m high 3 cycles, then DONE with FinalDataMemoryRead_m=0xDEADBEEF, faults 0.
- LB addr 0x103, rdata=0x80112233 → 0xFFFFFF80. LBU same → 0x00000080. LHU addr 0x102 → 0x00008011.
- SB addr 0x201, WriteData_m=0x000000A5 → dmem_addr=0x200, wstrb=0010, wdata=0xA5A5A5A5, we=1. Write ack → DONE. req_ready low 4 cycles → req fields stable and stall held throughout.
- LW addr 0x102 → no req_valid ever, stall_m 1 cycle, DONE with access_fault_m=1, data 0. funct3=011 behaves the same.
- LW, no response, TIMEOUT_CYCLES=16 → 16 WAIT cycles, then DONE with bus_err_m=1. A rsp_valid one cycle later causes no state change. rsp_err=1 on a normal response → bus_err_m=1, data 0.
- reset pulsed low while in WAIT → req_valid/stall_m 0 immediately, state IDLE. After release, a pending rsp_valid is ignored and the next LW completes normally.
